// File: rtl/ccff_chain_loader.sv
// Serialises parallel bitstream words onto the ccff_head -> ccff_tail configuration chain.
// An optional recirculation pass reads the chain back and compares CRC-8 signatures.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 4,
    parameter int WORD_W    = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              verify_en,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              crc_err,
    output logic [7:0]        crc_value
);

    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [7:0] CRC_POLY = 8'h07;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_VERIFY, ST_DONE} state_t;

    state_t            state_reg, state_next;
    logic              verify_reg;
    logic [WORD_W-1:0] buf_reg;
    logic              buf_full_reg, buf_full_next;
    logic [BW-1:0]     bidx_reg;
    logic [CW-1:0]     ccnt_reg;
    logic [7:0]        crc_load_reg, crc_load_next;
    logic [7:0]        crc_rb_reg, crc_rb_next;
    logic [7:0]        crc_value_reg;
    logic              crc_err_reg;
    logic              shift_en_reg, shift_en_next;

    logic              load_shift;
    logic              last_bit;
    logic              chain_last;
    logic              handshake;
    logic [31:0]       pending;
    logic              load_fb, rb_fb;
    logic [7:0]        crc_load_step, crc_rb_step;

    assign load_shift = (state_reg == ST_LOAD) && buf_full_reg;
    assign last_bit   = (bidx_reg == BW'(WORD_W - 1));
    assign chain_last = (ccnt_reg == CW'(CHAIN_LEN - 1));
    // Bits already shifted plus bits still waiting in the buffer.
    assign pending    = 32'(ccnt_reg) + (buf_full_reg ? (32'(WORD_W) - 32'(bidx_reg)) : 32'd0);
    assign handshake  = word_ready && word_valid;

    assign load_fb = crc_load_reg[7] ^ ccff_head;
    assign rb_fb   = crc_rb_reg[7] ^ ccff_tail;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_crc
            if (gi == 0) begin : g_lsb
                assign crc_load_step[gi] = load_fb & CRC_POLY[gi];
                assign crc_rb_step[gi]   = rb_fb & CRC_POLY[gi];
            end else begin : g_bit
                assign crc_load_step[gi] = crc_load_reg[gi-1] ^ (load_fb & CRC_POLY[gi]);
                assign crc_rb_step[gi]   = crc_rb_reg[gi-1] ^ (rb_fb & CRC_POLY[gi]);
            end
        end
    endgenerate

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state_reg     <= ST_IDLE;
            verify_reg    <= 1'b0;
            buf_reg       <= '0;
            buf_full_reg  <= 1'b0;
            bidx_reg      <= '0;
            ccnt_reg      <= '0;
            crc_load_reg  <= 8'h00;
            crc_rb_reg    <= 8'h00;
            crc_value_reg <= 8'h00;
            crc_err_reg   <= 1'b0;
            shift_en_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            buf_full_reg <= buf_full_next;
            shift_en_reg <= shift_en_next;
            crc_load_reg <= crc_load_next;
            crc_rb_reg   <= crc_rb_next;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        verify_reg    <= verify_en;
                        ccnt_reg      <= '0;
                        bidx_reg      <= '0;
                        crc_value_reg <= 8'h00;
                        crc_err_reg   <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (load_shift) begin
                        ccnt_reg <= chain_last ? '0 : ccnt_reg + CW'(1);
                        bidx_reg <= bidx_reg + BW'(1);
                    end
                    if (handshake) begin
                        buf_reg  <= word_data;
                        bidx_reg <= '0;
                    end
                end
                ST_VERIFY: ccnt_reg <= chain_last ? '0 : ccnt_reg + CW'(1);
                default: ;
            endcase
            // Results appear in the done cycle itself, so capture the final CRCs on entry.
            if (state_next == ST_DONE && state_reg != ST_DONE) begin
                crc_value_reg <= crc_load_next;
                crc_err_reg   <= verify_reg && (crc_rb_next != crc_load_next);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_LOAD;
            ST_LOAD:   if (load_shift && chain_last) state_next = verify_reg ? ST_VERIFY : ST_DONE;
            ST_VERIFY: if (chain_last) state_next = ST_DONE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        buf_full_next = 1'b0;
        crc_load_next = crc_load_reg;
        crc_rb_next   = crc_rb_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    crc_load_next = 8'h00;
                    crc_rb_next   = 8'h00;
                end
            end
            ST_LOAD: begin
                if (load_shift) crc_load_next = crc_load_step;
                if (handshake) buf_full_next = 1'b1;
                else if (load_shift && (last_bit || chain_last)) buf_full_next = 1'b0;
                else buf_full_next = buf_full_reg;
            end
            ST_VERIFY: crc_rb_next = crc_rb_step;
            default: ;
        endcase
        // Registered so the prog_clk gate enable only moves right after a rising edge.
        shift_en_next = ((state_next == ST_LOAD) && buf_full_next) || (state_next == ST_VERIFY);
    end

    always_comb begin
        word_ready = (state_reg == ST_LOAD) && (pending < 32'(CHAIN_LEN))
                     && (!buf_full_reg || last_bit);
        ccff_head = 1'b0;
        if (load_shift) ccff_head = buf_reg[bidx_reg];
        else if (state_reg == ST_VERIFY) ccff_head = ccff_tail;
        ccff_shift_en = shift_en_reg;
        busy          = (state_reg == ST_LOAD) || (state_reg == ST_VERIFY);
        done          = (state_reg == ST_DONE);
        crc_value     = crc_value_reg;
        crc_err       = crc_err_reg;
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Randomised bench for ccff_chain_loader: two chain lengths, a behavioural chain,
// and a reference built from the bit list, polynomial division and cycle arithmetic.
module tb_ccff_chain_loader;

    localparam int CL0 = 4;
    localparam int CL1 = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  prst_v, start_v, verify_v, valid_v, flip_v;
    logic [1:0]  ready_v, head_v, shen_v, tail_v, busy_v, done_v, err_v;
    logic [15:0] data_v, crcv_v;
    logic [31:0] chain0 = '0;
    logic [31:0] chain1 = '0;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] wq[$];
    int         gq[$];
    logic [7:0] last_crc;
    logic       last_err;

    ccff_chain_loader #(.CHAIN_LEN(CL0), .WORD_W(8)) dut0 (
        .prog_clk(clk), .pReset(prst_v[0]), .start(start_v[0]), .verify_en(verify_v[0]),
        .word_data(data_v[7:0]), .word_valid(valid_v[0]), .word_ready(ready_v[0]),
        .ccff_head(head_v[0]), .ccff_shift_en(shen_v[0]), .ccff_tail(tail_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .crc_err(err_v[0]), .crc_value(crcv_v[7:0])
    );

    ccff_chain_loader #(.CHAIN_LEN(CL1), .WORD_W(8)) dut1 (
        .prog_clk(clk), .pReset(prst_v[1]), .start(start_v[1]), .verify_en(verify_v[1]),
        .word_data(data_v[15:8]), .word_valid(valid_v[1]), .word_ready(ready_v[1]),
        .ccff_head(head_v[1]), .ccff_shift_en(shen_v[1]), .ccff_tail(tail_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .crc_err(err_v[1]), .crc_value(crcv_v[15:8])
    );

    // Fabric chain: shifts ccff_head in at the head on every enabled prog_clk edge.
    always @(posedge clk) if (shen_v[0]) chain0 <= {chain0[30:0], head_v[0] ^ flip_v[0]};
    always @(posedge clk) if (shen_v[1]) chain1 <= {chain1[30:0], head_v[1] ^ flip_v[1]};
    assign tail_v[0] = chain0[CL0-1];
    assign tail_v[1] = chain1[CL1-1];

    function automatic int cl_of(input int d);
        return (d == 0) ? CL0 : CL1;
    endfunction

    // CRC-8 as the remainder of message(x) * x^8 divided by x^8+x^2+x+1.
    function automatic logic [7:0] crc8_ref(input logic [31:0] bits, input int n);
        logic [63:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r = (r << 1) | 64'(bits[k]);
        r = r << 8;
        for (int p = n + 7; p >= 8; p--)
            if (r[p]) r = r ^ (64'h107 << (p - 8));
        return r[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Enter and leave at posedge+1. Words come from wq, per-word stall gaps from gq.
    task automatic run_op(input int d, input bit ver, input int corrupt);
        int cl, nw, wi, gap, iter, hs_cnt, sh_cnt, stall_cnt, done_iter, rc_mis, sum_gap;
        logic [31:0] head_bits, tail_bits, exp_bits, exp_tail, exp_chain, mask, chain_now;
        logic [7:0] exp_crc, b, got_crc;
        bit done_seen, got_err;
        cl = cl_of(d);
        nw = wq.size();
        exp_bits = '0;
        for (int k = 0; k < cl; k++) begin
            b = wq[k / 8];
            exp_bits[k] = b[k % 8];
        end
        exp_tail = exp_bits;
        if (corrupt >= 0) exp_tail[corrupt] = ~exp_tail[corrupt];
        exp_chain = '0;
        for (int k = 0; k < cl; k++) exp_chain[cl - 1 - k] = exp_tail[k];
        mask = (32'd1 << cl) - 32'd1;
        exp_crc = crc8_ref(exp_bits, cl);
        sum_gap = 0;
        foreach (gq[i]) sum_gap += gq[i];

        start_v[d] = 1'b1;
        verify_v[d] = ver;
        @(posedge clk); #1;
        wi = 0; gap = gq[0]; iter = 0; hs_cnt = 0; sh_cnt = 0; stall_cnt = 0;
        done_iter = 0; rc_mis = 0; done_seen = 0; head_bits = '0; tail_bits = '0;
        got_crc = '0; got_err = 0;
        while (!done_seen && iter < 200) begin
            iter++;
            start_v[d]  = ($urandom_range(0, 3) == 0);
            verify_v[d] = 1'($urandom_range(0, 1));
            flip_v[d]   = (corrupt == sh_cnt) && shen_v[d];
            if (wi < nw) begin
                data_v[d*8 +: 8] = wq[wi];
                if (gap > 0) begin
                    valid_v[d] = ready_v[d] ? 1'b0 : 1'($urandom_range(0, 1));
                    if (ready_v[d]) gap--;
                end else begin
                    valid_v[d] = 1'b1;
                end
            end else begin
                valid_v[d] = 1'($urandom_range(0, 1));
                data_v[d*8 +: 8] = 8'($urandom);
            end
            @(negedge clk);
            if (ready_v[d] && valid_v[d]) begin
                hs_cnt++;
                wi++;
                if (wi < nw) gap = gq[wi];
            end
            if (shen_v[d]) begin
                if (sh_cnt < cl) head_bits[sh_cnt] = head_v[d];
                else if (sh_cnt < 2 * cl) begin
                    tail_bits[sh_cnt - cl] = tail_v[d];
                    if (head_v[d] !== tail_v[d]) rc_mis++;
                end
                sh_cnt++;
            end else if (busy_v[d]) begin
                stall_cnt++;
            end
            if (done_v[d]) begin
                done_seen = 1;
                done_iter = iter;
                got_crc = crcv_v[d*8 +: 8];
                got_err = err_v[d];
            end
            @(posedge clk); #1;
        end
        start_v[d] = 1'b0;
        flip_v[d]  = 1'b0;
        chain_now  = (d == 0) ? chain0 : chain1;

        check("done_seen", 32'(done_seen), 32'd1);
        check("latency", done_iter, 2 + cl + (ver ? cl : 0) + sum_gap);
        check("handshakes", hs_cnt, (cl + 7) / 8);
        check("shifts", sh_cnt, ver ? 2 * cl : cl);
        check("stalls", stall_cnt, 1 + sum_gap);
        check("head_seq", head_bits & mask, exp_bits);
        if (ver) begin
            check("tail_seq", tail_bits & mask, exp_tail);
            check("recirc", rc_mis, 0);
        end
        check("chain", chain_now & mask, exp_chain);
        check("crc_value", 32'(got_crc), 32'(exp_crc));
        check("crc_err", 32'(got_err), 32'(ver && corrupt >= 0));

        // Back in IDLE: stray valid is refused, results hold.
        valid_v[d] = 1'b1;
        data_v[d*8 +: 8] = 8'($urandom);
        @(negedge clk);
        check("idle_ready", 32'(ready_v[d]), 32'd0);
        check("idle_busy", 32'(busy_v[d]), 32'd0);
        check("idle_done", 32'(done_v[d]), 32'd0);
        check("idle_shift", 32'(shen_v[d]), 32'd0);
        check("crc_hold", 32'(crcv_v[d*8 +: 8]), 32'(exp_crc));
        check("err_hold", 32'(err_v[d]), 32'(ver && corrupt >= 0));
        @(posedge clk); #1;
        valid_v[d] = 1'b0;
        last_crc = got_crc;
        last_err = got_err;
        $display("op dut=%0d len=%0d verify=%0d words=%0d gaps=%0d corrupt=%0d crc=%02h err=%0d latency=%0d",
                 d, cl, ver, nw, sum_gap, corrupt, got_crc, got_err, done_iter);
    endtask

    task automatic run_reset(input int d);
        int sh, it;
        sh = 0;
        it = 0;
        start_v[d] = 1'b1;
        verify_v[d] = 1'b1;
        @(posedge clk); #1;
        start_v[d] = 1'b0;
        valid_v[d] = 1'b1;
        data_v[d*8 +: 8] = 8'hFF;
        while (sh < 2 && it < 20) begin
            @(negedge clk);
            if (shen_v[d]) sh++;
            @(posedge clk); #1;
            it++;
            start_v[d] = 1'b1;
        end
        check("rst_two_shifts", sh, 2);
        prst_v[d] = 1'b1;
        @(posedge clk); #1;
        prst_v[d] = 1'b0;
        start_v[d] = 1'b0;
        valid_v[d] = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy_v[d]), 32'd0);
        check("rst_shift", 32'(shen_v[d]), 32'd0);
        check("rst_ready", 32'(ready_v[d]), 32'd0);
        check("rst_done", 32'(done_v[d]), 32'd0);
        @(posedge clk); #1;
        valid_v[d] = 1'b0;
        @(negedge clk);
        check("rst_stays_idle", 32'(busy_v[d]), 32'd0);
        @(posedge clk); #1;
        $display("op dut=%0d reset during load after %0d shifts", d, sh);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, cl, nw, corrupt;
        bit ver;
        prst_v = 2'b11; start_v = '0; verify_v = '0; valid_v = 2'b11; flip_v = '0;
        data_v = 16'hFFFF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("reset_ready%0d", i), 32'(ready_v[i]), 32'd0);
            check($sformatf("reset_head%0d", i), 32'(head_v[i]), 32'd0);
            check($sformatf("reset_shift%0d", i), 32'(shen_v[i]), 32'd0);
            check($sformatf("reset_busy%0d", i), 32'(busy_v[i]), 32'd0);
            check($sformatf("reset_done%0d", i), 32'(done_v[i]), 32'd0);
            check($sformatf("reset_err%0d", i), 32'(err_v[i]), 32'd0);
            check($sformatf("reset_crc%0d", i), 32'(crcv_v[i*8 +: 8]), 32'd0);
        end
        @(posedge clk); #1;
        prst_v = '0;
        valid_v = '0;

        wq = '{8'h0B}; gq = '{0};
        run_op(0, 1, -1);
        check("crc_0x0B", 32'(last_crc), 32'h23);

        wq = '{8'hA5, 8'h3C, 8'hFF}; gq = '{0, 0, 0};
        run_op(1, 0, -1);
        gq = '{0, 3, 3};
        run_op(1, 0, -1);
        check("stall_crc", 32'(last_crc), 32'(crc8_ref(32'h0F3CA5, 20)));

        wq = '{8'h0B}; gq = '{0};
        run_op(0, 1, 2);
        check("flip_err", 32'(last_err), 32'd1);
        run_op(0, 0, -1);

        run_reset(0);
        wq = '{8'h0B}; gq = '{0};
        run_op(0, 1, -1);

        for (int r = 0; r < 14; r++) begin
            d = $urandom_range(0, 1);
            cl = cl_of(d);
            nw = (cl + 7) / 8;
            ver = 1'($urandom_range(0, 1));
            corrupt = (ver && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, cl - 1)) : -1;
            wq.delete();
            gq.delete();
            for (int k = 0; k < nw; k++) begin
                wq.push_back(8'($urandom));
                gq.push_back(int'($urandom_range(0, 3)));
            end
            run_op(d, ver, corrupt);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
